// File: rtl/cla_4bit.sv
// Registered 4-bit carry-lookahead slice with group propagate/generate export.
// Latency 1 cycle, one addition per cycle; no handshake, so operands are taken every edge.
module cla_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       group_p,
  output logic       group_g
);

  logic [3:0] g;
  logic [3:0] p;
  logic       c1;
  logic       c2;
  logic       c3;
  logic       c4;
  logic [3:0] sum_nxt;
  logic       gp_nxt;
  logic       gg_nxt;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is a flat SOP of p/g and the carry-in; none is built from another carry.
  assign c1 = g[0]
            | (p[0] & c);
  assign c2 = g[1]
            | (p[1] & g[0])
            | (p[1] & p[0] & c);
  assign c3 = g[2]
            | (p[2] & g[1])
            | (p[2] & p[1] & g[0])
            | (p[2] & p[1] & p[0] & c);
  assign c4 = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & c);

  assign gp_nxt = p[3] & p[2] & p[1] & p[0];
  assign gg_nxt = g[3]
                | (p[3] & g[2])
                | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0]);

  assign sum_nxt = p ^ {c3, c2, c1, c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum     <= 4'h0;
      c_out   <= 1'b0;
      group_p <= 1'b0;
      group_g <= 1'b0;
    end else begin
      sum     <= sum_nxt;
      c_out   <= c4;
      group_p <= gp_nxt;
      group_g <= gg_nxt;
    end
  end

endmodule

// File: tb/tb_cla_4bit.sv
// Self-checking bench for cla_4bit against an arithmetic reference model.
module tb_cla_4bit;

  logic       clk;
  logic       rst_n;
  logic [3:0] a;
  logic [3:0] b;
  logic       c;
  logic [3:0] sum;
  logic       c_out;
  logic       group_p;
  logic       group_g;

  int checks;
  int errors;

  cla_4bit dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a       (a),
    .b       (b),
    .c       (c),
    .sum     (sum),
    .c_out   (c_out),
    .group_p (group_p),
    .group_g (group_g)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Model: {group_g, group_p, c_out, sum[3:0]} from plain integer arithmetic.
  function automatic logic [6:0] model(input logic [3:0] ma, input logic [3:0] mb, input logic mc);
    int total;
    int nocarry;
    logic pp;
    logic gg;
    total   = int'(ma) + int'(mb) + int'(mc);
    nocarry = int'(ma) + int'(mb);
    pp      = ((ma ^ mb) == 4'hF);
    gg      = (nocarry > 15);
    model   = {gg, pp, (total > 15), 4'(total % 16)};
  endfunction

  function automatic logic [6:0] observed();
    observed = {group_g, group_p, c_out, sum};
  endfunction

  task automatic apply(input logic [3:0] na, input logic [3:0] nb, input logic nc);
    a = na;
    b = nb;
    c = nc;
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    apply(4'hF, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) begin
      next_edge();
      checks++;
      if (observed() !== 7'h00) begin
        errors++;
        $display("FAIL reset_hold: got gg/gp/co/sum=%b required=%b", observed(), 7'h00);
      end
    end
    rst_n = 1'b1;
    next_edge();
    checks++;
    if (observed() !== model(4'hF, 4'hF, 1'b1)) begin
      errors++;
      $display("FAIL reset_release: got %b required=%b", observed(), model(4'hF, 4'hF, 1'b1));
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (observed() !== 7'h00) begin
      errors++;
      $display("FAIL reset_async: got %b required=%b", observed(), 7'h00);
    end
    next_edge();
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [3:0]  ta [5];
    logic [3:0]  tb [5];
    logic        tc [5];
    logic [6:0]  te [5];
    ta = '{4'hF, 4'h5, 4'hF, 4'hF, 4'h0};
    tb = '{4'h0, 4'hA, 4'hF, 4'hF, 4'h0};
    tc = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    // Hand-derived {gg, gp, c_out, sum}.
    te = '{7'b0_1_1_0000, 7'b0_1_0_1111, 7'b1_0_1_1111, 7'b1_0_1_1110, 7'b0_0_0_0000};
    for (int i = 0; i < 5; i++) begin
      apply(ta[i], tb[i], tc[i]);
      next_edge();
      checks++;
      if (observed() !== te[i]) begin
        errors++;
        $display("FAIL directed[%0d] a=%h b=%h c=%b: got %b required=%b",
                 i, ta[i], tb[i], tc[i], observed(), te[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [8:0] v;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      if (i == 300) begin
        rst_n = 1'b0;
        #1;
        checks++;
        if (observed() !== 7'h00) begin
          errors++;
          $display("FAIL midreset_async: got %b required=%b", observed(), 7'h00);
        end
        for (int k = 0; k < 3; k++) begin
          next_edge();
          checks++;
          if (observed() !== 7'h00) begin
            errors++;
            $display("FAIL midreset_hold[%0d]: got %b required=%b", k, observed(), 7'h00);
          end
        end
        rst_n = 1'b1;
      end
      apply(v[3:0], v[7:4], v[8]);
      next_edge();
      checks++;
      if (observed() !== model(v[3:0], v[7:4], v[8])) begin
        errors++;
        $display("FAIL sweep a=%h b=%h c=%b: got %b required=%b",
                 v[3:0], v[7:4], v[8], observed(), model(v[3:0], v[7:4], v[8]));
      end
      checks++;
      if (c_out !== (group_g | (group_p & v[8]))) begin
        errors++;
        $display("FAIL invariant a=%h b=%h c=%b: c_out=%b required=%b",
                 v[3:0], v[7:4], v[8], c_out, group_g | (group_p & v[8]));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea [3];
    logic [3:0] eb [3];
    logic       ec [3];
    logic [4:0] ex [3];
    ea = '{4'h3, 4'h8, 4'h9};
    eb = '{4'h4, 4'h8, 4'h6};
    ec = '{1'b0, 1'b0, 1'b1};
    ex = '{5'b0_0111, 5'b1_0000, 5'b1_0000};
    for (int i = 0; i < 3; i++) begin
      apply(ea[i], eb[i], ec[i]);
      next_edge();
      checks++;
      if ({c_out, sum} !== ex[i]) begin
        errors++;
        $display("FAIL back_to_back[%0d]: got c_out/sum=%b required=%b", i, {c_out, sum}, ex[i]);
      end
    end
  endtask

  task automatic test_between_edges();
    logic [6:0] held;
    apply(4'h2, 4'h3, 1'b0);
    next_edge();
    held = model(4'h2, 4'h3, 1'b0);
    apply(4'hF, 4'h1, 1'b1);
    #1;
    apply(4'h9, 4'h9, 1'b1);
    #1;
    checks++;
    if (observed() !== held) begin
      errors++;
      $display("FAIL between_edges: got %b required=%b", observed(), held);
    end
    next_edge();
    checks++;
    if (observed() !== model(4'h9, 4'h9, 1'b1)) begin
      errors++;
      $display("FAIL between_edges_capture: got %b required=%b", observed(), model(4'h9, 4'h9, 1'b1));
    end
  endtask

  task automatic test_random();
    logic [3:0] ra;
    logic [3:0] rb;
    logic       rc;
    for (int i = 0; i < 200; i++) begin
      ra = 4'($urandom_range(15));
      rb = 4'($urandom_range(15));
      rc = 1'($urandom_range(1));
      apply(ra, rb, rc);
      next_edge();
      checks++;
      if (observed() !== model(ra, rb, rc)) begin
        errors++;
        $display("FAIL random a=%h b=%h c=%b: got %b required=%b",
                 ra, rb, rc, observed(), model(ra, rb, rc));
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    a      = 4'h0;
    b      = 4'h0;
    c      = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_back_to_back();
    test_between_edges();
    test_sweep();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
